wb16_master: RTL and testbench

WB16_MASTER -- requirements
Module: wb16_master

---
 rtl/wb16_master_if.sv | 22 ++
 rtl/wb16_master.sv | 143 ++++++++++++++
 tb/tb_wb16_master.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wb16_master_if.sv
// Wishbone 16-bit bus bundle between wb16_master and its slave.
// Signal names keep the master-side _o/_i suffixes so both ends read the same.
interface wb16_master_if;
  logic [31:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb16_master.sv
// Single-transaction Wishbone master: byte/half/word access over a 16-bit
// big-endian bus, word split into two beats separated by one idle-strobe gap.
module wb16_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [1:0]    size_i,
  input  logic [31:0]   adr_i,
  input  logic [31:0]   dat_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [31:0]   rdat_o,
  wb16_master_if.master wb
);

  typedef enum logic [1:0] {IDLE, BEAT, GAP, ERR} state_e;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [1:0]  size_q;
  logic        lane_q;     // adr[0] of a byte access: 1 selects bits 7:0
  logic        beat1_q;
  logic [15:0] dat_lo_q;
  logic [7:0]  tmo_q;
  logic        last_beat;

  assign last_beat = (size_q != SZ_WORD) || beat1_q;
  assign busy_o    = (state_q != IDLE);

  // NOTE: every register here, bus outputs included, updates with <= so all
  // branches see the values from before the edge, never a half-updated mix.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      size_q      <= '0;
      lane_q      <= 1'b0;
      beat1_q     <= 1'b0;
      dat_lo_q    <= '0;
      tmo_q       <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      rdat_o      <= '0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_sel_o <= '0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            size_q   <= size_i;
            lane_q   <= adr_i[0];
            dat_lo_q <= dat_i[15:0];
            if (size_i == 2'b11 || (size_i != SZ_BYTE && adr_i[0])) begin
              state_q <= ERR;
              done_o  <= 1'b1;
              err_o   <= 1'b1;
              rdat_o  <= '0;
            end else begin
              state_q     <= BEAT;
              beat1_q     <= 1'b0;
              tmo_q       <= '0;
              wb.wb_cyc_o <= 1'b1;
              wb.wb_stb_o <= 1'b1;
              wb.wb_we_o  <= we_i;
              wb.wb_adr_o <= adr_i;
              case (size_i)
                SZ_BYTE: begin
                  wb.wb_sel_o <= adr_i[0] ? 2'b01 : 2'b10;
                  wb.wb_dat_o <= {dat_i[7:0], dat_i[7:0]};
                end
                SZ_HALF: begin
                  wb.wb_sel_o <= 2'b11;
                  wb.wb_dat_o <= dat_i[15:0];
                end
                default: begin
                  wb.wb_sel_o <= 2'b11;
                  wb.wb_dat_o <= dat_i[31:16];
                end
              endcase
            end
          end
        end

        BEAT: begin
          // ACK wins over a timeout that expires in the same cycle
          if (wb.wb_ack_i) begin
            state_q     <= GAP;
            wb.wb_stb_o <= 1'b0;
            wb.wb_cyc_o <= !last_beat;
            done_o      <= last_beat;
            case (size_q)
              SZ_BYTE: rdat_o <= {24'h0, lane_q ? wb.wb_dat_i[7:0] : wb.wb_dat_i[15:8]};
              SZ_HALF: rdat_o <= {16'h0, wb.wb_dat_i};
              default: rdat_o <= beat1_q ? {rdat_o[31:16], wb.wb_dat_i}
                                         : {wb.wb_dat_i, 16'h0};
            endcase
          end else if (tmo_q == TMO_LAST) begin
            state_q     <= ERR;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            done_o      <= 1'b1;
            err_o       <= 1'b1;
            rdat_o      <= '0;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end

        GAP: begin
          if (!last_beat) begin
            state_q     <= BEAT;
            beat1_q     <= 1'b1;
            tmo_q       <= '0;
            wb.wb_stb_o <= 1'b1;
            wb.wb_adr_o <= wb.wb_adr_o + 32'd2;
            wb.wb_dat_o <= dat_lo_q;
          end else begin
            state_q    <= IDLE;
            wb.wb_we_o <= 1'b0;
          end
        end

        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb16_master.sv
// Randomized bench for wb16_master: a wait-state slave drives the bus and each
// transaction is scored against expectations derived from size/address/latency.
module tb_wb16_master;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i, we_i;
  logic [1:0]  size_i;
  logic [31:0] adr_i, dat_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdat_o;

  wb16_master_if wb ();

  wb16_master #(.TIMEOUT(TMO)) dut (
    .clk_i (clk),   .rst_i (rst_i), .req_i (req_i), .we_i (we_i),
    .size_i(size_i), .adr_i(adr_i), .dat_i(dat_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdat_o(rdat_o),
    .wb    (wb)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Slave memory: a few fixed words, otherwise an address-derived pattern.
  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0000_0100) return 16'h1234;
    if (a == 32'h0000_0102) return 16'h5678;
    return a[15:0] ^ a[31:16] ^ 16'hA5C3;
  endfunction

  // Slave: ACK after `lat` strobe cycles; optional one-cycle ACK hangover.
  int lat  = 1;
  bit hold = 1'b0;
  int stb_cnt = 0;
  bit slv_prev_stb = 1'b0;

  always @(negedge clk) begin
    if (wb.wb_cyc_o && wb.wb_stb_o) begin
      if (stb_cnt >= lat) begin
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = mem_rd(wb.wb_adr_o);
      end else begin
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = 16'($urandom);
      end
      stb_cnt++;
    end else begin
      wb.wb_ack_i = hold && wb.wb_ack_i && slv_prev_stb;
      wb.wb_dat_i = 16'($urandom);
      stb_cnt = 0;
    end
    slv_prev_stb = wb.wb_stb_o;
  end

  typedef struct packed {
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        we;
  } beat_t;

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // first idle cycle after done_o so the next call tests earliest accept.
  task automatic do_txn(input string name, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        input int l, input bit h);
    bit          mis, tmo, saw_done, unstable, bad_inv, prev_stb;
    int          nb, exp_lat, n, done_n, gapcyc, stbcyc;
    logic [15:0] m0, m1;
    logic [31:0] exp_rd, got_rd;
    logic        got_err;
    beat_t       q[$];
    beat_t       cur, now;

    mis     = (sz == 2'b11) || (sz != 2'b00 && a[0]);
    tmo     = !mis && (l >= TMO);
    nb      = mis ? 0 : tmo ? 1 : (sz == 2'b10 ? 2 : 1);
    exp_lat = mis ? 1 : tmo ? TMO + 1 : nb * (l + 2);
    m0 = mem_rd(a);
    m1 = mem_rd(a + 32'd2);
    if (mis || tmo)      exp_rd = 32'h0;
    else if (sz == 2'b00) exp_rd = {24'h0, a[0] ? m0[7:0] : m0[15:8]};
    else if (sz == 2'b01) exp_rd = {16'h0, m0};
    else                  exp_rd = {m0, m1};

    lat = l; hold = h;
    req_i = 1'b1; we_i = we; size_i = sz; adr_i = a; dat_i = d;
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = ~we; size_i = 2'($urandom); adr_i = $urandom; dat_i = $urandom;

    n = 0; done_n = 0; gapcyc = 0; stbcyc = 0; got_err = 1'b0; got_rd = '0;
    saw_done = 0; unstable = 0; bad_inv = 0; prev_stb = 0; cur = '0;
    while (n < 40 && !saw_done) begin
      @(negedge clk);
      n++;
      now = '{wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o, wb.wb_we_o};
      if (wb.wb_stb_o && !prev_stb) begin
        cur = now;
        q.push_back(now);
      end else if (wb.wb_stb_o && now != cur) unstable = 1;
      if (wb.wb_stb_o) stbcyc++;
      if (wb.wb_cyc_o && !wb.wb_stb_o) gapcyc++;
      if (err_o && !done_o) bad_inv = 1;
      prev_stb = wb.wb_stb_o;
      if (done_o) begin
        saw_done = 1; done_n = n; got_err = err_o; got_rd = rdat_o;
      end
    end

    check({name, " done seen"}, 32'(saw_done), 32'd1);
    check({name, " latency"},   done_n, exp_lat);
    check({name, " err"},       32'(got_err), 32'(mis || tmo));
    check({name, " rdat"},      got_rd, exp_rd);
    check({name, " beats"},     q.size(), nb);
    check({name, " stb cycles"}, stbcyc, mis ? 0 : tmo ? TMO : nb * (l + 1));
    check({name, " gap cyc"},   gapcyc, (nb == 2) ? 1 : 0);
    check({name, " stb stable"}, 32'(unstable), 32'd0);
    check({name, " err w/o done"}, 32'(bad_inv), 32'd0);
    for (int i = 0; i < q.size() && i < nb; i++) begin
      check({name, " beat adr"}, q[i].adr, a + 32'(2 * i));
      check({name, " beat sel"}, 32'(q[i].sel), (sz == 2'b00) ? (a[0] ? 32'h1 : 32'h2) : 32'h3);
      check({name, " beat we"},  32'(q[i].we), 32'(we));
      if (we) begin
        if (sz == 2'b00)      check({name, " beat dat"}, 32'(q[i].dat), {16'h0, d[7:0], d[7:0]});
        else if (sz == 2'b01) check({name, " beat dat"}, 32'(q[i].dat), {16'h0, d[15:0]});
        else                  check({name, " beat dat"}, 32'(q[i].dat), (i == 0) ? {16'h0, d[31:16]} : {16'h0, d[15:0]});
      end
    end

    @(negedge clk);
    check({name, " idle busy"}, 32'(busy_o), 32'd0);
    check({name, " idle done"}, 32'(done_o), 32'd0);
    check({name, " idle cyc"},  32'(wb.wb_cyc_o), 32'd0);
    check({name, " rdat hold"}, rdat_o, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_in_reset;
    int rises;
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = '0; adr_i = '0; dat_i = '0;
    wb.wb_ack_i = 1'b0; wb.wb_dat_i = '0;
    #1;
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset cyc",  32'({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}), 32'd0);
    check("reset rdat", rdat_o, 32'd0);
    check("reset adr",  wb.wb_adr_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;

    do_txn("word rd 0x100",  1'b0, 2'b10, 32'h0000_0100, 32'h0,          1,  1'b0);
    do_txn("byte wr 0x11",   1'b1, 2'b00, 32'h0000_0011, 32'h0000_00AB,  1,  1'b0);
    do_txn("half rd mis",    1'b0, 2'b01, 32'h0000_0003, 32'h0,          1,  1'b0);
    do_txn("timeout",        1'b0, 2'b01, 32'h0000_0020, 32'h0,          10, 1'b0);
    do_txn("word wr hold",   1'b1, 2'b10, 32'h0000_0300, 32'hCAFE_F00D,  1,  1'b1);
    do_txn("word rd wrap",   1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,          0,  1'b0);
    do_txn("size 11",        1'b1, 2'b11, 32'h0000_0040, 32'h1111_2222,  1,  1'b0);
    do_txn("ack at limit",   1'b0, 2'b00, 32'h0000_0050, 32'h0,          TMO - 1, 1'b0);

    // Reset in the middle of the second beat of a word write.
    lat = 1; hold = 1'b0;
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; adr_i = 32'h0000_0200; dat_i = 32'h89AB_CDEF;
    @(posedge clk);
    #1 req_i = 1'b0;
    rises = 0;
    for (int i = 0; i < 20 && rises < 2; i++) begin
      @(negedge clk);
      if (wb.wb_stb_o && !slv_prev_stb) rises++;
    end
    check("rst reached beat 1", rises, 2);
    #2 rst_i = 1'b0;
    #1;
    check("rst cyc/stb", 32'({wb.wb_cyc_o, wb.wb_stb_o}), 32'd0);
    check("rst busy",    32'(busy_o), 32'd0);
    check("rst we/sel",  32'({wb.wb_we_o, wb.wb_sel_o}), 32'd0);
    done_in_reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_o) done_in_reset = 1'b1;
    end
    check("rst no done", 32'(done_in_reset), 32'd0);
    rst_i = 1'b1;
    do_txn("half rd after rst", 1'b0, 2'b01, 32'h0000_0042, 32'h0, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          l;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'b00) a[0] = 1'b0;
      l  = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, TMO - 1);
      do_txn("random", 1'($urandom), sz, a, $urandom, l, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
